// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and two-byte instruction fetch front end for the decoder;
//            presents each instruction for EXEC and holds the Z/C flags.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    output logic                rom_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic                rom_ack,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   operand,
    output logic                exec_valid,
    input  logic                pc_en,
    input  logic                pc_load,
    input  logic                halt,
    input  logic                alu_en,
    input  logic [DATA_W-1:0]   data_bus,
    input  logic                alu_zero,
    input  logic                alu_carry,
    input  logic                io_done,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                halted,
    output logic [ADDR_W-1:0]   pc
);

    typedef enum logic [1:0] {
        ST_FETCH_OP  = 2'd0,
        ST_FETCH_ARG = 2'd1,
        ST_EXEC      = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [OPCODE_W-1:0] r_ir_op;
    logic [DATA_W-1:0]   r_ir_arg;
    logic                r_zero;
    logic                r_carry;
    logic                r_rom_req;
    logic                w_fetching;
    logic                w_fire;
    logic                w_exec;
    logic [ADDR_W-1:0]   w_jump_target;

    // Jump target is the low ADDR_W bits of the bus, zero-extended if the bus is narrower.
    generate
        if (DATA_W >= ADDR_W) begin : g_jump_trunc
            assign w_jump_target = data_bus[ADDR_W-1:0];
            if (DATA_W > ADDR_W) begin : g_bus_unused
                logic w_unused_bus;
                assign w_unused_bus = &{1'b0, data_bus[DATA_W-1:ADDR_W]};
            end
        end else begin : g_jump_zext
            assign w_jump_target = {{(ADDR_W-DATA_W){1'b0}}, data_bus};
        end
    endgenerate

    generate
        if (DATA_W > OPCODE_W) begin : g_op_unused
            logic w_unused_op;
            assign w_unused_op = &{1'b0, rom_data[DATA_W-1:OPCODE_W]};
        end
    endgenerate

    assign w_fetching = (r_state == ST_FETCH_OP) || (r_state == ST_FETCH_ARG);
    // An ack only counts against our own outstanding request.
    assign w_fire     = w_fetching && r_rom_req && rom_ack;
    assign w_exec     = (r_state == ST_EXEC);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH_OP: begin
                if (w_fire) w_next_state = ST_FETCH_ARG;
            end
            ST_FETCH_ARG: begin
                if (w_fire) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt)
                    w_next_state = ST_HALTED;
                else if (pc_load || pc_en || io_done)
                    w_next_state = ST_FETCH_OP;
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_FETCH_OP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH_OP;
            r_pc      <= '0;
            r_ir_op   <= '0;
            r_ir_arg  <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_rom_req <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Request drops on the accepting edge, giving one idle cycle before the next.
            if (w_fetching)
                r_rom_req <= !w_fire;
            else
                r_rom_req <= 1'b0;

            if (w_fire) begin
                r_pc <= r_pc + 1'b1;
                if (r_state == ST_FETCH_OP)
                    r_ir_op <= rom_data[OPCODE_W-1:0];
                else
                    r_ir_arg <= rom_data;
            end else if (w_exec && !halt && pc_load) begin
                r_pc <= w_jump_target;
            end

            if (w_exec && alu_en) begin
                r_zero  <= alu_zero;
                r_carry <= alu_carry;
            end
        end
    end

    assign rom_req    = r_rom_req;
    assign rom_addr   = r_pc;
    assign pc         = r_pc;
    assign exec_valid = w_exec;
    assign opcode     = w_exec ? r_ir_op  : '0;
    assign operand    = w_exec ? r_ir_arg : '0;
    assign halted     = (r_state == ST_HALTED);
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed self-checking bench for fetch_sequencer with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int OPCODE_W = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rom_req;
    logic [ADDR_W-1:0]   rom_addr;
    logic                rom_ack;
    logic [DATA_W-1:0]   rom_data;
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   operand;
    logic                exec_valid;
    logic                pc_en = 1'b1;
    logic                pc_load = 1'b0;
    logic                halt = 1'b0;
    logic                alu_en = 1'b0;
    logic [DATA_W-1:0]   data_bus = '0;
    logic                alu_zero = 1'b0;
    logic                alu_carry = 1'b0;
    logic                io_done = 1'b0;
    logic                zero_flag;
    logic                carry_flag;
    logic                halted;
    logic [ADDR_W-1:0]   pc;

    logic [7:0] rom [256];
    int         wait_cycles = 0;
    int         ack_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OPCODE_W (OPCODE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .opcode     (opcode),
        .operand    (operand),
        .exec_valid (exec_valid),
        .pc_en      (pc_en),
        .pc_load    (pc_load),
        .halt       (halt),
        .alu_en     (alu_en),
        .data_bus   (data_bus),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .io_done    (io_done),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .halted     (halted),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // ROM answers after wait_cycles cycles of a held request.
    always @(posedge clk) begin
        if (!rom_req || rom_ack)
            ack_cnt <= 0;
        else
            ack_cnt <= ack_cnt + 1;
    end
    assign rom_ack  = rom_req && (ack_cnt == wait_cycles);
    assign rom_data = rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_exec();
        int n = 0;
        @(negedge clk);
        while (!exec_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("exec_seen", {31'd0, exec_valid}, 32'd1);
    endtask

    task automatic wait_req();
        int n = 0;
        @(negedge clk);
        while (!rom_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("req_seen", {31'd0, rom_req}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit stable;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", {24'd0, pc}, 32'h0);
        check("rst_req", {31'd0, rom_req}, 32'd0);
        check("rst_exec", {31'd0, exec_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_opcode", {27'd0, opcode}, 32'd0);
        check("rst_operand", {24'd0, operand}, 32'd0);
        check("rst_flags", {30'd0, zero_flag, carry_flag}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'd0, rom_req}, 32'd1);
        check("first_addr", {24'd0, rom_addr}, 32'h0);

        // Basic program {01,2A,13,00} with single-cycle acks, second instr halts
        rom[0] = 8'h01; rom[1] = 8'h2A; rom[2] = 8'h13; rom[3] = 8'h00;
        do_reset();
        wait_exec();
        check("t1_opcode", {27'd0, opcode}, 32'h01);
        check("t1_operand", {24'd0, operand}, 32'h2A);
        check("t1_pc", {24'd0, pc}, 32'h02);
        @(posedge clk); #1 halt = 1'b1;
        wait_exec();
        check("t1_opcode2", {27'd0, opcode}, 32'h13);
        @(negedge clk);
        check("t1_halted", {31'd0, halted}, 32'd1);
        check("t1_halt_pc", {24'd0, pc}, 32'h04);
        check("t1_halt_exec", {31'd0, exec_valid}, 32'd0);
        check("t1_halt_opcode", {27'd0, opcode}, 32'd0);
        repeat (3) @(negedge clk);
        check("t1_halt_hold", {30'd0, halted, rom_req}, 32'b10);
        halt = 1'b0;

        // Three wait states, then a 5-cycle I/O stall released by io_done
        rom[0] = 8'h05; rom[1] = 8'h77;
        wait_cycles = 3;
        pc_en = 1'b0;
        do_reset();
        wait_req();
        n = 0;
        stable = 1'b1;
        while (rom_req && n < 20) begin
            n++;
            if (rom_addr !== 8'h00) stable = 1'b0;
            @(negedge clk);
        end
        check("t2_req_cycles", n, 32'd4);
        check("t2_addr_stable", {31'd0, stable}, 32'd1);
        wait_exec();
        check("t2_opcode", {27'd0, opcode}, 32'h05);
        check("t2_operand", {24'd0, operand}, 32'h77);
        n = 0;
        while (exec_valid && n < 20) begin
            n++;
            io_done = (n == 6);
            @(negedge clk);
        end
        io_done = 1'b0;
        pc_en = 1'b1;
        check("t2_exec_cycles", n, 32'd6);
        check("t2_pc_after", {24'd0, pc}, 32'h02);
        wait_cycles = 0;

        // Jump to 0x10, then halt+pc_load halts without jumping
        rom[2] = 8'h02; rom[3] = 8'h00; rom[8'h10] = 8'hE3; rom[8'h11] = 8'h55;
        pc_load = 1'b1;
        data_bus = 8'h10;
        wait_exec();
        check("t3_opcode", {27'd0, opcode}, 32'h02);
        @(posedge clk); #1 halt = 1'b1; data_bus = 8'h30;
        wait_req();
        check("t3_jump_addr", {24'd0, rom_addr}, 32'h10);
        wait_exec();
        check("t3_opcode_trunc", {27'd0, opcode}, 32'h03);
        check("t3_operand", {24'd0, operand}, 32'h55);
        @(negedge clk);
        check("t3_halted", {31'd0, halted}, 32'd1);
        check("t3_halt_pc", {24'd0, pc}, 32'h12);
        halt = 1'b0;
        pc_load = 1'b0;

        // Flags update only in EXEC with alu_en; PC wraps 0xFF -> 0x00
        rom[0] = 8'h04; rom[1] = 8'h01; rom[2] = 8'h06; rom[3] = 8'h02;
        rom[8'hFE] = 8'h07; rom[8'hFF] = 8'h09;
        alu_en = 1'b1; alu_zero = 1'b1; alu_carry = 1'b0;
        do_reset();
        wait_exec();
        check("t4_flags_pre", {30'd0, zero_flag, carry_flag}, 32'b00);
        @(posedge clk); #1 alu_zero = 1'b0; alu_carry = 1'b1;
        @(negedge clk);
        check("t4_flags_set", {30'd0, zero_flag, carry_flag}, 32'b10);
        wait_exec();
        check("t4_flags_fetch_hold", {30'd0, zero_flag, carry_flag}, 32'b10);
        alu_en = 1'b0; pc_load = 1'b1; data_bus = 8'hFE;
        @(posedge clk); #1 pc_load = 1'b0;
        @(negedge clk);
        check("t4_flags_noalu_hold", {30'd0, zero_flag, carry_flag}, 32'b10);
        check("t4_jump_fe", {24'd0, rom_addr}, 32'hFE);
        wait_exec();
        check("t4_opcode", {27'd0, opcode}, 32'h07);
        check("t4_operand", {24'd0, operand}, 32'h09);
        check("t4_pc_wrap", {24'd0, pc}, 32'h00);
        alu_carry = 1'b0;

        // Reset mid FETCH_ARG with an ack pending
        rom[0] = 8'h0B; rom[1] = 8'h44;
        wait_cycles = 3;
        do_reset();
        n = 0;
        @(negedge clk);
        while (!(rom_req && rom_ack && rom_addr == 8'h01) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t5_ack_pending", {31'd0, rom_ack}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_pc", {24'd0, pc}, 32'h00);
        check("t5_rst_req", {31'd0, rom_req}, 32'd0);
        check("t5_rst_opcode", {27'd0, opcode}, 32'd0);
        check("t5_rst_exec", {31'd0, exec_valid}, 32'd0);
        rst = 1'b0;
        wait_cycles = 0;
        wait_exec();
        check("t5_opcode", {27'd0, opcode}, 32'h0B);
        check("t5_operand", {24'd0, operand}, 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
